// File: rtl/fadd_pkg.sv
// fadd_pkg: shared widths, bypass threshold and controller state encoding for the FP adder.
package fadd_pkg;
  localparam int MANT_W = 28;
  localparam int EXP_W = 8;
  localparam int BYPASS_DIFF = 26;
  localparam int CNT_W = 5;
  typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, ROUND, RNORM, DONE} fadd_state_t;
endpackage

// File: rtl/fadd_ctrl_if.sv
// fadd_ctrl_if: start/status flags from the datapath and strobes back to it.
interface fadd_ctrl_if;
  import fadd_pkg::*;
  logic start;
  logic [EXP_W-1:0] exp_diff;
  logic a_ge_b;
  logic special;
  logic alu_cout;
  logic mant_msb;
  logic mant_zero;
  logic exp_is_min;
  logic exp_is_max;
  logic round_cout;
  logic busy;
  logic done;
  logic swap;
  logic ld_ops;
  logic align_shift;
  logic alu_en;
  logic norm_r;
  logic norm_l;
  logic round_en;
  logic fra_sel;
  logic ovf;
  logic zero_res;
  modport master (
    input start, exp_diff, a_ge_b, special, alu_cout, mant_msb, mant_zero,
          exp_is_min, exp_is_max, round_cout,
    output busy, done, swap, ld_ops, align_shift, alu_en, norm_r, norm_l,
           round_en, fra_sel, ovf, zero_res
  );
  modport slave (
    output start, exp_diff, a_ge_b, special, alu_cout, mant_msb, mant_zero,
           exp_is_min, exp_is_max, round_cout,
    input busy, done, swap, ld_ops, align_shift, alu_en, norm_r, norm_l,
          round_en, fra_sel, ovf, zero_res
  );
endinterface

// File: rtl/fadd_shift_cnt.sv
// fadd_shift_cnt: loadable down-counter pacing the alignment shifts.
module fadd_shift_cnt
  import fadd_pkg::*;
(
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] d,
  output logic             is_one,
  output logic             is_zero
);
  logic [CNT_W-1:0] q;
  always_ff @(posedge clk or negedge res)
    if (!res) q <= '0;
    else if (load) q <= d;
    else if (dec && q != '0) q <= q - CNT_W'(1);
  assign is_one = q == CNT_W'(1);
  assign is_zero = q == '0;
endmodule

// File: rtl/fadd_ctrl.sv
// fadd_ctrl: sequences compare, align, add, normalise and round for the FP adder datapath.
module fadd_ctrl
  import fadd_pkg::*;
(
  input  logic           clk,
  input  logic           res,
  fadd_ctrl_if.master    bus
);
  fadd_state_t state, nxt;
  logic accept, first, byp, cnt_one, cnt_zero;
  logic swap_q, fra_q, ovf_q, zero_q;
  logic norm_r, norm_l, set_ovf, set_zero;
  assign accept = state == IDLE && bus.start;
  fadd_shift_cnt u_cnt (
    .clk(clk),
    .res(res),
    .load(accept),
    .dec(state == ALIGN),
    .d(bus.exp_diff[CNT_W-1:0]),
    .is_one(cnt_one),
    .is_zero(cnt_zero)
  );
  // Operand flags are only valid with start, so the bypass decision is latched then.
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      state <= IDLE;
      first <= 1'b0;
      byp <= 1'b0;
      swap_q <= 1'b0;
      fra_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state <= nxt;
      first <= state == ADD;
      byp <= accept ? bus.special | (bus.exp_diff > EXP_W'(BYPASS_DIFF)) : byp;
      swap_q <= accept ? ~bus.a_ge_b : swap_q;
      fra_q <= state == CMP ? ~byp : fra_q;
      ovf_q <= accept ? 1'b0 : ovf_q | set_ovf;
      zero_q <= accept ? 1'b0 : zero_q | set_zero;
    end
  // Adder carry is only meaningful on the first NORM cycle, right after ADD.
  always_comb begin
    nxt = state;
    norm_r = 1'b0;
    norm_l = 1'b0;
    set_ovf = 1'b0;
    set_zero = 1'b0;
    case (state)
      IDLE:  nxt = bus.start ? CMP : IDLE;
      CMP:   nxt = byp ? DONE : cnt_zero ? ADD : ALIGN;
      ALIGN: nxt = cnt_one ? ADD : ALIGN;
      ADD:   nxt = NORM;
      NORM:
        if (first && bus.alu_cout) begin
          norm_r = 1'b1;
          set_ovf = bus.exp_is_max;
          nxt = bus.exp_is_max ? DONE : NORM;
        end else if (bus.mant_zero) begin
          set_zero = 1'b1;
          nxt = DONE;
        end else if (!bus.mant_msb && !bus.exp_is_min) norm_l = 1'b1;
        else nxt = ROUND;
      ROUND: nxt = bus.round_cout ? RNORM : DONE;
      RNORM: begin
        norm_r = 1'b1;
        set_ovf = bus.exp_is_max;
        nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.ld_ops = accept;
  assign bus.align_shift = state == ALIGN;
  assign bus.alu_en = state == ADD;
  assign bus.norm_r = norm_r;
  assign bus.norm_l = norm_l;
  assign bus.round_en = state == ROUND;
  assign bus.swap = swap_q;
  assign bus.fra_sel = fra_q;
  assign bus.ovf = ovf_q;
  assign bus.zero_res = zero_q;
endmodule

// File: tb/tb_fadd_ctrl.sv
// tb_fadd_ctrl: directed vectors for the FP adder controller with hand-computed latencies.
module tb_fadd_ctrl;
  logic clk = 1'b0;
  logic res = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  fadd_ctrl_if bus ();
  fadd_ctrl dut (.clk(clk), .res(res), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {bus.busy, bus.done, bus.swap, bus.fra_sel, bus.ovf, bus.zero_res,
            bus.align_shift, bus.alu_en, bus.norm_r, bus.norm_l, bus.round_en};
  endfunction

  // nl = number of NORM cycles with mant_msb low; ign = pulse start mid-operation
  task automatic op(input string tag, input logic [7:0] ed, input logic ageb, sp, cout, mz,
                    emax, rc, input int nl, ign, e_lat, e_al, e_nr, e_nl, e_alu, e_rnd,
                    input logic e_fra, e_swap, e_ovf, e_zero);
    int lat = 0, al = 0, nr = 0, nlc = 0, alu = 0, rnd = 0, multi = 0;
    logic fra = 1'b0, sw = 1'b0, ov = 1'b0, zr = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.exp_diff = ed;
    bus.a_ge_b = ageb;
    bus.special = sp;
    bus.alu_cout = cout;
    bus.mant_zero = mz;
    bus.exp_is_max = emax;
    bus.round_cout = rc;
    bus.mant_msb = nl == 0;
    bus.exp_is_min = 1'b0;
    @(negedge clk);
    check({tag, " ld_ops"}, 32'(bus.ld_ops), 1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, " busy"}, 32'(bus.busy), 1);
      al += int'(bus.align_shift);
      nr += int'(bus.norm_r);
      nlc += int'(bus.norm_l);
      alu += int'(bus.alu_en);
      rnd += int'(bus.round_en);
      if (int'(bus.ld_ops) + int'(bus.align_shift) + int'(bus.alu_en) + int'(bus.norm_r)
          + int'(bus.norm_l) + int'(bus.round_en) > 1) multi++;
      if (bus.done) begin
        lat = c;
        fra = bus.fra_sel;
        sw = bus.swap;
        ov = bus.ovf;
        zr = bus.zero_res;
      end else begin
        @(posedge clk);
        #1;
        bus.mant_msb = nlc >= nl;
        bus.start = ign != 0 && (c == 2 || c == 3);
        bus.a_ge_b = bus.start ? ~ageb : ageb;
      end
    end
    check({tag, " latency"}, lat, e_lat);
    check({tag, " align_shift"}, al, e_al);
    check({tag, " norm_r"}, nr, e_nr);
    check({tag, " norm_l"}, nlc, e_nl);
    check({tag, " alu_en"}, alu, e_alu);
    check({tag, " round_en"}, rnd, e_rnd);
    check({tag, " strobe_excl"}, multi, 0);
    check({tag, " fra_sel"}, 32'(fra), 32'(e_fra));
    check({tag, " swap"}, 32'(sw), 32'(e_swap));
    check({tag, " ovf"}, 32'(ov), 32'(e_ovf));
    check({tag, " zero_res"}, 32'(zr), 32'(e_zero));
  endtask

  initial begin
    logic seen;
    {bus.start, bus.a_ge_b, bus.special, bus.alu_cout, bus.mant_msb, bus.mant_zero,
     bus.exp_is_min, bus.exp_is_max, bus.round_cout} = '0;
    bus.exp_diff = '0;
    @(negedge clk);
    check("reset outs", 32'(outs()), 0);
    @(posedge clk);
    #1 res = 1'b1;
    //      tag       ed  ab sp co mz mx rc nl ig lat al nr nl alu rnd fra sw ov zr
    op("diff0",     8'd0, 1, 0, 0, 0, 0, 0, 0, 0, 5,  0, 0, 0, 1,  1,  1, 0, 0, 0);
    op("diff3",     8'd3, 0, 0, 0, 0, 0, 0, 0, 0, 8,  3, 0, 0, 1,  1,  1, 1, 0, 0);
    op("bypass27", 8'd27, 1, 0, 0, 0, 0, 0, 0, 0, 2,  0, 0, 0, 0,  0,  0, 0, 0, 0);
    op("special",   8'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2,  0, 0, 0, 0,  0,  0, 0, 0, 0);
    op("diff26",   8'd26, 1, 0, 0, 0, 0, 0, 0, 0, 31, 26, 0, 0, 1, 1,  1, 0, 0, 0);
    op("cout_ovf",  8'd0, 1, 0, 1, 0, 1, 0, 0, 0, 4,  0, 1, 0, 1,  0,  1, 0, 1, 0);
    op("zero",      8'd0, 1, 0, 0, 1, 0, 0, 0, 0, 4,  0, 0, 0, 1,  0,  1, 0, 0, 1);
    op("cout_norm", 8'd0, 1, 0, 1, 0, 0, 0, 0, 0, 6,  0, 1, 0, 1,  1,  1, 0, 0, 0);
    op("norml_rnd", 8'd0, 1, 0, 0, 0, 0, 1, 4, 0, 10, 0, 1, 4, 1,  1,  1, 0, 0, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.exp_diff = 8'd10;
    bus.a_ge_b = 1'b0;
    bus.mant_msb = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid align_shift", 32'(bus.align_shift), 1);
    #1 res = 1'b0;
    #1 check("mid reset outs", 32'(outs()), 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= bus.done;
    end
    @(posedge clk);
    #1 res = 1'b1;
    repeat (15) begin
      @(negedge clk);
      seen |= bus.done;
    end
    check("mid no_done", 32'(seen), 0);
    op("ignore_start", 8'd3, 1, 0, 0, 0, 0, 0, 0, 1, 8, 3, 0, 0, 1, 1, 1, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
